eight_to_three_encoder: RTL and testbench
=========================================

# eight_to_three_encoder

Debounced, registered 8-to-3 priority encoder for the lab board's eight slide switches / push buttons. It synchronises and debounces the raw `switch` vector, encodes the highest active bit into a 3-bit code, and flags validity, multiple-active, and change events. It is the encode side of the 3-to-8 decoder path: its `code` output can drive the decoder's 3-bit `switch` input directly.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive cycles a new synchronised switch value must hold before acceptance; legal range ≥1. The board build overrides it, e.g. 500000 at 50 MHz ≈ 10 ms.
- `clk`  input  1  single system clock, rising-edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `switch`  input  8  raw, asynchronous switch levels; bit i high = input i active.
- `code`  output  3  index of highest active debounced bit; 0 when none active.
- `valid`  output  1  high when at least one debounced bit is active.
- `multi`  output  1  high when two or more debounced bits are active.
- `strobe`  output  1  one-cycle pulse when `{valid, code}` changes.

## Operation
- Synchroniser: two flops per bit, `sync1` then `sync2`. Reset value is 8'h00.
- Debounce state machine has two states, STABLE and SETTLING. Registers: `cand[7:0]`, `cnt`, and `stable[7:0]`.
  - `cnt` width is max(1, clog2(DEBOUNCE_CYCLES)).
  - Every cycle, first check: if `sync2 != cand`, then `cand <= sync2`, `cnt <= 0`, state → SETTLING. This check has priority over everything else.
  - Else, in SETTLING with `cnt == DEBOUNCE_CYCLES-1`: `stable <= cand`, state → STABLE.
  - Else, in SETTLING: `cnt <= cnt + 1`.
  - In STABLE with no mismatch: hold all registers.
- Any bounce during SETTLING restarts the count. No partial update of `stable` ever occurs.
- Output stage, registered once from `stable`:
  - Priority: highest set index wins. Examples: 8'b0010_0100 → `code` 5; 8'b1000_0001 → `code` 7.
  - `valid` = OR of `stable`.
  - `multi` = popcount(`stable`) ≥ 2.
  - `strobe` = 1 for exactly one cycle when the newly registered `{valid, code}` differs from its previous registered value.
- A change in `stable` that leaves `{valid, code}` unchanged gives no strobe. Example: 8'h80 → 8'h81 updates `multi` only.
- Reset (asynchronous assert, any time including mid-SETTLING):
  - `sync1`, `sync2`, `cand`, `stable` = 0; `cnt` = 0; state = STABLE.
  - `code` = 0, `valid` = 0, `multi` = 0, `strobe` = 0.
  - Release is synchronous to `clk` at board level. Switches held during reset are accepted as a normal change after release, with full latency and a strobe.

## Timing
- Latency: a value first sampled by `sync1` at edge 1 appears on `stable` at edge DEBOUNCE_CYCLES+3. Outputs update at edge DEBOUNCE_CYCLES+4 (edge 8 for the default).
- Acceptance requires `sync2` to hold the value for DEBOUNCE_CYCLES+1 consecutive samples. One fewer sample leaves the outputs unchanged.
- `strobe` is high during the cycle following edge DEBOUNCE_CYCLES+4 only, and never for two consecutive cycles.
- With DEBOUNCE_CYCLES=1, the value is accepted on the second `sync2` sample; latency is 5 edges.
- Switch returning to the old value mid-SETTLING: `cand` reloads and SETTLING restarts. Once the old value has been held long enough, `stable` is re-loaded with an identical value, so no strobe occurs.
- All outputs are glitch-free flop outputs. There is no combinational path from `switch` to any output.

## Test plan
- Reset, then `switch`=8'h00 held 20 cycles → `code`=0, `valid`=0, `multi`=0, `strobe` never high.
- `switch` 8'h00→8'h08 at edge 1, held (D=4) → `code`=3, `valid`=1, `multi`=0 after edge 8. `strobe` is high for exactly one cycle after edge 8; outputs unchanged after edge 7.
- `switch` 8'h24 held → `code`=5, `multi`=1, one strobe. Then 8'h25 held → `multi` stays 1, `code` stays 5, no strobe. Then 8'h80 held → `code`=7, `multi`=0, one strobe.
- Bounce: 8'h00→8'h02 for 3 cycles, back to 8'h00 for 2 cycles, 8'h02 for 4 cycles, back to 8'h00 → outputs stay 0, no strobe. Then 8'h02 for 5+ cycles → `code`=1, `valid`=1, one strobe.
- Assert `rst_n`=0 mid-SETTLING with `switch`=8'hFF → all outputs 0 immediately, without waiting for a clock edge. Release with 8'hFF held → `code`=7, `valid`=1, `multi`=1 on the 8th edge after release, plus one strobe.
- DEBOUNCE_CYCLES=1 build, `switch` 8'h00→8'h40 → `code`=6 at edge 5.

Source files
------------

// File: rtl/eight_to_three_encoder_if.sv
// Switch-encoder bus: raw switch levels in, encoded code and status flags out.
interface eight_to_three_encoder_if;
  logic [7:0] switch;
  logic [2:0] code;
  logic       valid;
  logic       multi;
  logic       strobe;

  modport master (output switch, input code, valid, multi, strobe);
  modport slave  (input switch, output code, valid, multi, strobe);
endinterface

// File: rtl/eight_to_three_encoder.sv
// Debounced, registered 8-to-3 priority encoder for the board switches.
// A two-flop synchroniser feeds a debounce FSM, and a registered encoder follows it.
module eight_to_three_encoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  eight_to_three_encoder_if.slave   bus
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {STABLE, SETTLING} state_t;

  state_t           state_q, state_d;
  logic [7:0]       sync1_q, sync2_q;
  logic [7:0]       cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       stable_q, stable_d;
  logic [2:0]       code_q, code_d;
  logic             valid_q, valid_d;
  logic             multi_q, multi_d;
  logic             strobe_q, strobe_d;

  // State register, synchroniser and output flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= STABLE;
      sync1_q  <= '0;
      sync2_q  <= '0;
      cand_q   <= '0;
      cnt_q    <= '0;
      stable_q <= '0;
      code_q   <= '0;
      valid_q  <= 1'b0;
      multi_q  <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync1_q  <= bus.switch;
      sync2_q  <= sync1_q;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      code_q   <= code_d;
      valid_q  <= valid_d;
      multi_q  <= multi_d;
      strobe_q <= strobe_d;
    end
  end

  // Next state: any mismatch against the candidate restarts settling first
  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync2_q != cand_q) begin
      cand_d  = sync2_q;
      cnt_d   = '0;
      state_d = SETTLING;
    end else if (state_q == SETTLING) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = cand_q;
        state_d  = STABLE;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Output stage: highest set index wins; strobe only when {valid, code} moves
  always_comb begin
    code_d = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (stable_q[i]) code_d = i[2:0];
    end
    valid_d  = |stable_q;
    multi_d  = (stable_q & (stable_q - 8'd1)) != '0;
    strobe_d = {valid_d, code_d} != {valid_q, code_q};
  end

  assign bus.code   = code_q;
  assign bus.valid  = valid_q;
  assign bus.multi  = multi_q;
  assign bus.strobe = strobe_q;

endmodule

// File: tb/tb_eight_to_three_encoder.sv
// Scoreboard bench for eight_to_three_encoder: default build plus a DEBOUNCE_CYCLES=1 build.
module tb_eight_to_three_encoder;

  localparam int D = 4;

  typedef struct packed {
    logic [2:0] code;
    logic       valid;
    logic       multi;
    logic       strobe;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  eight_to_three_encoder_if bus0 ();
  eight_to_three_encoder_if bus1 ();

  eight_to_three_encoder #(.DEBOUNCE_CYCLES(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0.slave)
  );

  eight_to_three_encoder #(.DEBOUNCE_CYCLES(1)) dut_d1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];

  // Model state: run of identical sampled values and the last accepted value
  logic [7:0] run_val;
  int         run_len;
  logic [7:0] acc;
  logic [3:0] prev_vc;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] top_index(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) return 3'(i);
    end
    return 3'd0;
  endfunction

  task automatic model_reset();
    sb_q.delete();
    for (int i = 0; i < 3; i++) sb_q.push_back('0);
    run_val = 8'h00;
    run_len = D + 1;
    acc     = 8'h00;
    prev_vc = 4'h0;
  endtask

  // A value is accepted once held for D+1 consecutive slots; outputs appear 3 edges after the last one
  task automatic model_push(input logic [7:0] v);
    exp_t e;
    if (v == run_val) run_len++;
    else begin
      run_val = v;
      run_len = 1;
    end
    if (run_len >= D + 1) acc = run_val;
    e.code   = top_index(acc);
    e.valid  = (acc != 8'h00);
    e.multi  = ($countones(acc) >= 2);
    e.strobe = ({e.valid, e.code} != prev_vc);
    prev_vc  = {e.valid, e.code};
    sb_q.push_back(e);
  endtask

  task automatic step(input logic [7:0] v);
    exp_t e;
    bus0.switch = v;
    model_push(v);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check_eq("code",   8'(bus0.code),   8'(e.code));
    check_eq("valid",  8'(bus0.valid),  8'(e.valid));
    check_eq("multi",  8'(bus0.multi),  8'(e.multi));
    check_eq("strobe", 8'(bus0.strobe), 8'(e.strobe));
  endtask

  task automatic hold(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) step(v);
  endtask

  initial begin
    bus0.switch = 8'h00;
    bus1.switch = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_code",   8'(bus0.code),   8'h0);
    check_eq("rst_valid",  8'(bus0.valid),  8'h0);
    check_eq("rst_multi",  8'(bus0.multi),  8'h0);
    check_eq("rst_strobe", 8'(bus0.strobe), 8'h0);
    rst_n = 1'b1;
    model_reset();

    hold(8'h00, 20);
    hold(8'h08, 12);
    hold(8'h24, 10);
    hold(8'h25, 10);
    hold(8'h80, 10);
    hold(8'h00, 10);

    // Bounce: runs too short to be accepted, then a long enough one
    hold(8'h02, 3);
    hold(8'h00, 2);
    hold(8'h02, 4);
    hold(8'h00, 10);
    hold(8'h02, 10);
    hold(8'h81, 10);
    hold(8'h01, 10);

    // Asynchronous reset in the middle of settling
    hold(8'hFF, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_code",   8'(bus0.code),   8'h0);
    check_eq("arst_valid",  8'(bus0.valid),  8'h0);
    check_eq("arst_multi",  8'(bus0.multi),  8'h0);
    check_eq("arst_strobe", 8'(bus0.strobe), 8'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    hold(8'hFF, 12);
    hold(8'h10, 12);

    // Minimum-debounce build: accepted code appears at edge 5 with a single strobe
    bus1.switch = 8'h40;
    for (int e = 1; e <= 7; e++) begin
      @(posedge clk);
      #1;
      check_eq($sformatf("d1_code_e%0d", e),   8'(bus1.code),   (e >= 5) ? 8'h6 : 8'h0);
      check_eq($sformatf("d1_valid_e%0d", e),  8'(bus1.valid),  (e >= 5) ? 8'h1 : 8'h0);
      check_eq($sformatf("d1_strobe_e%0d", e), 8'(bus1.strobe), (e == 5) ? 8'h1 : 8'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
